display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Presents one BCD digit at a time to the shared BCD-to-7-segment decoder and drives active-low digit enables in step.
- Double-buffered display value: updates commit only at frame boundaries, so no torn frames.
- Dead-time between digits suppresses ghosting.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 50000, clk cycles each digit is lit (>=1).
- DEAD, 2, clk cycles all digits are off between slots (0 = no gap state).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = scan display; 0 = all digits off.
- load  input  1  single-cycle strobe; capture value_in and dp_in.
- value_in  input  4*NUM_DIGITS  packed BCD; digit i = value_in[4i+3:4i]; digit 0 = least significant.
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
- bcd_out  output  4  code to the shared decoder; 4'hF = blank.
- dp_out  output  1  decimal point, active-low (0 = lit).
- digit_sel_n  output  NUM_DIGITS  active-low digit enables; at most one bit low.
- frame_tick  output  1  one-cycle pulse at the end of each completed frame.

Behaviour:
- All outputs registered. Reset values: bcd_out=4'hF, dp_out=1, digit_sel_n=all ones, frame_tick=0.
- Reset state: FSM=IDLE, digit index=0, slot counter=0, display and pending registers cleared, pending flag=0.
- FSM states: IDLE, ON, GAP.
- IDLE:
  - Outputs at blank/off values.
  - The edge sampling enable=1 enters ON with index 0. On that same edge, digit_sel_n[0]=0 and bcd_out=display digit 0.
- ON:
  - Lit for exactly PRESCALE cycles.
  - Then enters GAP if DEAD>0, else ON with the next index.
- GAP:
  - digit_sel_n=all ones, bcd_out=4'hF, dp_out=1 for exactly DEAD cycles.
  - Then enters ON with the next index.
- Index wraps NUM_DIGITS-1 -> 0.
- Frame period = NUM_DIGITS*(PRESCALE+DEAD) cycles.
- frame_tick pulses on the edge where the index wraps to 0.
- Load/commit:
  - load=1 copies value_in/dp_in into the pending register and sets the pending flag. A later load before commit overwrites the pending value; newest wins.
  - Commit (pending -> display, flag cleared) occurs on the wrap edge. The digit-0 slot starting on that edge already shows the new value.
  - In IDLE, load commits directly on its own edge.
  - If load coincides with a wrap edge, the value_in on that cycle is committed directly.
- enable=0 while in ON/GAP: next edge -> IDLE, outputs to off values, index and slot counter reset to 0. Pending data is retained.
- Re-enabling always restarts at digit 0 with a full PRESCALE slot.
- BCD codes 10..15 pass through unchanged; the decoder blanks them.
- Invariant: digit_sel_n never has more than one zero, including on every transition edge.
- Reset asserted mid-scan: immediate return to reset values; no glitch pulses on digit_sel_n.

Optional Feature:
- Macro: DISPLAY_SCAN_LZB_EN.
- Defined (leading-zero blanking, applied at output selection):
  - Scanning from digit NUM_DIGITS-1 downward, every 0 digit above the most significant nonzero digit is output as bcd_out=4'hF.
  - Digit 0 is never blanked.
  - dp_out of a blanked digit still follows dp_in.
- Undefined: every digit output exactly as stored; zeros shown as 0.

Test Plan (PRESCALE=4, DEAD=1, NUM_DIGITS=4):
1. Reset, enable=1, load value 16'h1234, dp=4'b0000:
   - digit_sel_n cycles 1110/1111/1101/1111/1011/1111/0111/1111; each lit phase lasts 4 cycles, each gap 1 cycle.
   - bcd_out shows 4,3,2,1 during the lit phases.
   - frame_tick pulses every 20 cycles.
2. Mid-frame load of 16'h5678 while 16'h1234 is displayed:
   - Remaining digits of the current frame still show 1234.
   - After frame_tick, digit 0 shows 8.
   - Two loads in one frame: only the last is shown.
3. enable dropped during digit 2:
   - Next edge: digit_sel_n=1111, bcd_out=F.
   - Re-enable restarts at digit 0 for a full 4-cycle slot.
4. Reset asserted mid-slot:
   - digit_sel_n=1111, bcd_out=F, dp_out=1 asynchronously.
   - After release with enable=1, display shows 0000.
5. dp_in=4'b0100, value 16'h0A07:
   - dp_out=0 only during digit 2.
   - bcd_out=A passes through on digit 2.
   - With DISPLAY_SCAN_LZB_EN, value 16'h0007 gives F,F,F,7 on digits 3..0; value 16'h0000 gives F,F,F,0.
6. DEAD=0 build:
   - Digits switch back-to-back with no all-off cycle; frame period 16 cycles.
   - digit_sel_n never has two zeros on any edge.

Source files
------------

// File: rtl/display_scan_if.sv
// display_scan_if: control inputs and display outputs of the scan controller
interface display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [3:0]              bcd_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_sel_n;
  logic                    frame_tick;
  modport master (
    output enable, load, value_in, dp_in,
    input  bcd_out, dp_out, digit_sel_n, frame_tick
  );
  modport slave (
    input  enable, load, value_in, dp_in,
    output bcd_out, dp_out, digit_sel_n, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: double-buffered 7-seg digit scanner; DISPLAY_SCAN_LZB_EN adds leading-zero blanking
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int DEAD       = 2
) (
  input logic            clk,
  input logic            rst_n,
  display_scan_if.slave  bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2((PRESCALE > DEAD ? PRESCALE : DEAD) + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DEAD > 0 ? DEAD - 1 : 0);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [IW-1:0]           idx, idx_nx, idx_inc;
  logic [4*NUM_DIGITS-1:0] disp, disp_nx, pend, pend_nx;
  logic [NUM_DIGITS-1:0]   dpd, dpd_nx, pdp, pdp_nx;
  logic                    pflag, pflag_nx;
  logic                    slot_end, wrap, direct, blank;
  logic [3:0]              bcd_nx;
  logic                    dp_nx;
  logic [NUM_DIGITS-1:0]   sel_nx;
  // a frame wraps when the last slot of the last digit ends while still enabled
  assign slot_end = DEAD > 0 ? (state == GAP && cnt == D_LAST) : (state == ON && cnt == P_LAST);
  assign wrap     = bus.enable && slot_end && idx == I_LAST;
  assign idx_inc  = idx == I_LAST ? '0 : idx + IW'(1);
  // loads go straight to the display when nothing is being scanned or a new frame starts now
  assign direct   = bus.load && (state == IDLE || wrap);
  assign disp_nx  = direct ? bus.value_in : (wrap && pflag) ? pend : disp;
  assign dpd_nx   = direct ? bus.dp_in : (wrap && pflag) ? pdp : dpd;
  assign pend_nx  = (bus.load && !direct) ? bus.value_in : pend;
  assign pdp_nx   = (bus.load && !direct) ? bus.dp_in : pdp;
  assign pflag_nx = (bus.load && !direct) ? 1'b1 : (direct || wrap) ? 1'b0 : pflag;
`ifdef DISPLAY_SCAN_LZB_EN
  assign blank = idx_nx != '0 && (disp_nx >> (4 * idx_nx)) == '0;
`else
  assign blank = 1'b0;
`endif
  // scan state, slot counter and digit index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  // slot sequencing: ON for PRESCALE cycles, optional GAP for DEAD cycles, drop to IDLE when disabled
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    idx_nx   = idx;
    if (!bus.enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else
      case (state)
        IDLE: begin
          state_nx = ON;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
        ON: if (cnt == P_LAST) begin
          cnt_nx   = '0;
          state_nx = DEAD > 0 ? GAP : ON;
          idx_nx   = DEAD > 0 ? idx : idx_inc;
        end
        GAP: if (cnt == D_LAST) begin
          state_nx = ON;
          cnt_nx   = '0;
          idx_nx   = idx_inc;
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
  end
  // outputs are derived from the next state so they change on the same edge as the FSM
  always_comb begin
    sel_nx = state_nx == ON ? ~(NUM_DIGITS'(1) << idx_nx) : '1;
    bcd_nx = (state_nx != ON || blank) ? 4'hF : disp_nx[4*idx_nx +: 4];
    dp_nx  = state_nx == ON ? ~dpd_nx[idx_nx] : 1'b1;
  end
  // display and pending buffers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      disp  <= '0;
      dpd   <= '0;
      pend  <= '0;
      pdp   <= '0;
      pflag <= 1'b0;
    end else begin
      disp  <= disp_nx;
      dpd   <= dpd_nx;
      pend  <= pend_nx;
      pdp   <= pdp_nx;
      pflag <= pflag_nx;
    end
  // registered display outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.bcd_out     <= 4'hF;
      bus.dp_out      <= 1'b1;
      bus.digit_sel_n <= '1;
      bus.frame_tick  <= 1'b0;
    end else begin
      bus.bcd_out     <= bcd_nx;
      bus.dp_out      <= dp_nx;
      bus.digit_sel_n <= sel_nx;
      bus.frame_tick  <= wrap;
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized scoreboard bench for display_scan_ctrl
module tb_display_scan_ctrl;
  localparam int N = 4, P = 4, D = 1, SLOT = P + D, FRAME = N * SLOT;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  display_scan_if #(.NUM_DIGITS(N)) bus ();
  display_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic [3:0] bcd; logic dp; logic [N-1:0] sel; logic tick;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int t = -1;
  logic [4*N-1:0] disp = '0, pend = '0;
  logic [N-1:0] dpd = '0, pdp = '0;
  logic pflag = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  // expected outputs from the time elapsed since enabling and the committed value
  function automatic exp_t predict(input logic wrap);
    exp_t e;
    int dig;
    logic z;
    e.bcd = 4'hF; e.dp = 1'b1; e.sel = '1; e.tick = wrap;
    if (t >= 0 && t % SLOT < P) begin
      dig = (t / SLOT) % N;
      e.sel = ~(N'(1) << dig);
      e.bcd = disp[4*dig +: 4];
      e.dp = ~dpd[dig];
`ifdef DISPLAY_SCAN_LZB_EN
      z = dig > 0;
      for (int j = dig; j < N; j++) if (disp[4*j +: 4] != 4'h0) z = 0;
      if (z) e.bcd = 4'hF;
`else
      z = 0;
`endif
    end
    return e;
  endfunction
  task automatic step(input logic en, input logic ld, input logic [4*N-1:0] v, input logic [N-1:0] d);
    logic wrap;
    wrap = 0;
    bus.enable = en; bus.load = ld; bus.value_in = v; bus.dp_in = d;
    if (t < 0) begin
      if (ld) begin disp = v; dpd = d; pflag = 0; end
      if (en) t = 0;
    end else if (!en) begin
      t = -1;
      if (ld) begin pend = v; pdp = d; pflag = 1; end
    end else begin
      t++;
      wrap = t % FRAME == 0;
      if (wrap && ld) begin disp = v; dpd = d; pflag = 0; end
      else if (wrap && pflag) begin disp = pend; dpd = pdp; pflag = 0; end
      else if (ld) begin pend = v; pdp = d; pflag = 1; end
    end
    @(posedge clk);
    q.push_back(predict(wrap));
    #1;
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1, 0, '0, '0);
  endtask
  task automatic chk_off(input string name);
    chk({name, "_sel"}, 32'(bus.digit_sel_n), 32'({N{1'b1}}));
    chk({name, "_bcd"}, 32'(bus.bcd_out), 32'hF);
    chk({name, "_dp"}, 32'(bus.dp_out), 32'h1);
    chk({name, "_tick"}, 32'(bus.frame_tick), 32'h0);
  endtask
  // monitor: every cycle's outputs against the queued prediction
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sel", 32'(bus.digit_sel_n), 32'(e.sel));
      chk("bcd", 32'(bus.bcd_out), 32'(e.bcd));
      chk("dp", 32'(bus.dp_out), 32'(e.dp));
      chk("tick", 32'(bus.frame_tick), 32'(e.tick));
      chk("single_digit", 32'($countones(~bus.digit_sel_n) <= 1), 32'h1);
    end
  end
  initial begin
    logic found;
    bus.enable = 0; bus.load = 0; bus.value_in = '0; bus.dp_in = '0;
    repeat (3) @(negedge clk);
    chk_off("reset");
    rst_n = 1;
    step(1, 1, 16'h1234, 4'b0000);
    run(2 * FRAME);
    run(7);
    step(1, 1, 16'h5678, 4'b0000);
    run(FRAME + 3);
    step(1, 1, 16'h9999, 4'b0001);
    run(2);
    step(1, 1, 16'h1357, 4'b1000);
    run(2 * FRAME);
    found = 0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      step(1, 0, '0, '0);
      found = t >= 0 && (t / SLOT) % N == 2 && t % SLOT == 1;
    end
    chk("reach_digit2", 32'(found), 32'h1);
    step(0, 1, 16'h2468, 4'b0010);
    for (int k = 0; k < 3; k++) step(0, 0, '0, '0);
    run(2 * FRAME);
    found = 0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      step(1, 0, '0, '0);
      found = t % FRAME == FRAME - 1;
    end
    chk("reach_wrap", 32'(found), 32'h1);
    step(1, 1, 16'h4321, 4'b0001);
    run(FRAME + 6);
    #2 rst_n = 0;
    q.delete();
    #1 chk_off("async_reset");
    t = -1; disp = '0; dpd = '0; pend = '0; pdp = '0; pflag = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    run(FRAME + 2);
    step(0, 1, 16'h0A07, 4'b0100);
    run(2 * FRAME);
    step(0, 1, 16'h0007, 4'b0000);
    run(FRAME + 1);
    step(0, 1, 16'h0000, 4'b0011);
    run(FRAME + 1);
    for (int k = 0; k < 1500; k++) begin
      logic [4*N-1:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 14) == 0, v, N'($urandom));
    end
    @(negedge clk);
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
